instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 SHALL have port imem_req  output  1  instruction-memory request strobe.
REQ-005 SHALL have port imem_addr  output  32  word-aligned request address.
REQ-006 SHALL have port imem_gnt  input  1  memory accepts the request this cycle.
REQ-007 SHALL have port imem_rvalid  input  1  response data valid.
REQ-008 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump taken; load redirect_pc.
REQ-010 SHALL have port redirect_pc  input  32  branch/jump target.
REQ-011 SHALL have port dec_ready  input  1  decode/control stage can accept.
REQ-012 SHALL have port dec_valid  output  1  instruction presented to decode.
REQ-013 SHALL have ports dec_instr  output  32, dec_pc  output  32, opcode  output  6 (dec_instr[31:26]), funct  output  6 (dec_instr[5:0]).

Function
REQ-014 SHALL implement FSM states FETCH, WAIT_RESP, HOLD; at most one memory request outstanding.
REQ-015 FETCH: imem_req=1, imem_addr=pc; on imem_gnt go to WAIT_RESP, else stay with address stable.
REQ-016 WAIT_RESP: imem_req=0; on imem_rvalid capture imem_rdata and pc into output register, go to HOLD; imem_rvalid in FETCH or HOLD SHALL be ignored.
REQ-017 HOLD: dec_valid=1, dec_instr/dec_pc/opcode/funct stable until dec_valid&&dec_ready; on that handshake pc<=pc+4, state<=FETCH (imem_req high the next cycle).
REQ-018 Minimum latency: request cycle -> gnt same cycle -> rvalid next cycle -> dec_valid the cycle after (3 cycles request to present).
REQ-019 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 redirect_valid SHALL load pc<=redirect_pc with bits [1:0] forced to 0, in any state, taking priority over pc+4.
REQ-021 redirect in FETCH: if imem_gnt same cycle, go to WAIT_RESP with flush flag set; else stay in FETCH with new address next cycle.
REQ-022 redirect in WAIT_RESP (including same cycle as imem_rvalid): set flush; the flushed response SHALL be discarded, then go to FETCH; dec_valid never asserts for it.
REQ-023 redirect in HOLD without handshake: dec_valid SHALL drop next cycle (squash), state<=FETCH; with handshake same cycle the instruction is consumed, pc<=redirect target.
REQ-024 dec_valid SHALL never assert in FETCH or WAIT_RESP.

Reset
REQ-025 When rst_n=0 at a clk edge: pc<=RESET_PC, state<=FETCH, flush<=0, dec_valid<=0, dec_instr/dec_pc<=0, opcode/funct<=0, stall_cnt<=0; imem_req SHALL be 1 in the first cycle after reset release.
REQ-026 Reset mid-transaction SHALL abandon the outstanding request; no response received before reset release is presented.

Configuration
REQ-027 Macro FETCH_STALL_COUNT_EN defined: extra port stall_cnt  output  32, incremented each cycle dec_valid=1 and dec_ready=0, saturating at 32'hFFFF_FFFF.
REQ-028 Macro undefined: no stall_cnt port or counter logic; all other behaviour identical.

Structure
REQ-029 Shared package mips_pkg SHALL hold the FSM state enum, RESET_PC default, and opcode field positions (OPC_MSB=31, OPC_LSB=26, FUNCT_MSB=5).
REQ-030 One sub-module fetch_out_buf SHALL hold the output register (instr, pc, valid) with load/clear/squash controls.

Verification
REQ-031 Reset release, gnt immediate, rvalid 1 cycle later, dec_ready=1 -> dec_pc sequence 0x0, 0x4, 0x8 with imem_addr matching.
REQ-032 dec_ready=0 for 5 cycles in HOLD -> dec_instr stable, imem_req=0, stall_cnt=5 (macro defined).
REQ-033 redirect_valid with redirect_pc=0x0000_0103 while WAIT_RESP -> response discarded, next imem_addr=0x0000_0100, no dec_valid for flushed word.
REQ-034 RESET_PC=32'hFFFF_FFFC, one handshake -> next imem_addr=32'h0000_0000.
REQ-035 redirect in HOLD same cycle as dec_ready=1 -> instruction consumed once, next imem_addr=redirect target.
REQ-036 rst_n=0 while WAIT_RESP, rvalid arrives during reset -> after release dec_valid=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// +----------------------------------------------------------------------+
// | Package     : mips_pkg                                               |
// | Description : Shared types and constants for the instruction fetch   |
// |               unit: FSM state encoding, reset PC default and the     |
// |               instruction field positions used by decode.            |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

   // Fetch FSM states, explicitly encoded in two bits
   typedef enum logic [1:0] {
      FETCH     = 2'd0,
      WAIT_RESP = 2'd1,
      HOLD      = 2'd2
   } fetch_state_e;

   // Address of the first fetch after reset unless overridden
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Instruction field positions
   localparam int OPC_MSB   = 31;
   localparam int OPC_LSB   = 26;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;

   // Sequential fetch stride (one 32-bit word)
   localparam logic [31:0] PC_STEP = 32'd4;

   // Clear the byte offset so every fetch address is word aligned
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_out_buf.sv
// +----------------------------------------------------------------------+
// | Module      : fetch_out_buf                                          |
// | Description : Output register presented to decode. Holds the fetched |
// |               instruction, its PC and a valid flag. Load captures a  |
// |               fresh response, clear retires a consumed instruction,  |
// |               squash kills a presented instruction on a redirect.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_out_buf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_clear,
   input  logic        i_squash,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic        o_valid
);

   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic        r_valid;

   // Squash wins over load/clear; a killed instruction also drops its data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_instr <= 32'd0;
         r_pc    <= 32'd0;
         r_valid <= 1'b0;
      end else if (i_squash) begin
         r_instr <= 32'd0;
         r_pc    <= 32'd0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_instr <= i_instr;
         r_pc    <= i_pc;
         r_valid <= 1'b1;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end
   end

   assign o_instr = r_instr;
   assign o_pc    = r_pc;
   assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// +----------------------------------------------------------------------+
// | Module      : instr_fetch                                            |
// | Description : Single-outstanding instruction fetch unit. Issues one  |
// |               word request at a time, waits for the response, holds  |
// |               it for decode, and handles branch/jump redirects by    |
// |               flushing the in-flight or presented instruction.       |
// | Options     : FETCH_STALL_COUNT_EN - adds stall_cnt output counting  |
// |               cycles with dec_valid=1 and dec_ready=0 (saturating).  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        dec_ready,
   output logic        dec_valid,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   output logic [5:0]  opcode,
   output logic [5:0]  funct
`ifdef FETCH_STALL_COUNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;

   logic [31:0]  r_pc;
   logic         r_flush;     // in-flight response belongs to a stale path

   logic         w_dec_valid;
   logic         w_hs;
   logic         w_load;
   logic         w_clear;
   logic         w_squash;

   assign w_hs = w_dec_valid && dec_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: a flushed or redirected response returns to FETCH
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FETCH: begin
            if (imem_gnt) begin
               w_state_nxt = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            if (imem_rvalid) begin
               w_state_nxt = (r_flush || redirect_valid) ? FETCH : HOLD;
            end
         end
         HOLD: begin
            if (w_hs || redirect_valid) begin
               w_state_nxt = FETCH;
            end
         end
         default: begin
            w_state_nxt = FETCH;
         end
      endcase
   end

   // Output logic: memory strobe and output-buffer controls
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = r_pc;
      w_load    = 1'b0;
      w_clear   = 1'b0;
      w_squash  = 1'b0;
      case (r_state)
         FETCH: begin
            imem_req = 1'b1;
         end
         WAIT_RESP: begin
            w_load = imem_rvalid && !r_flush && !redirect_valid;
         end
         HOLD: begin
            w_clear  = w_hs;
            w_squash = redirect_valid && !w_hs;
         end
         default: begin
            imem_req = 1'b0;
         end
      endcase
   end

   // Program counter: redirect takes priority over sequential advance
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc <= word_align(RESET_PC);
      end else if (redirect_valid) begin
         r_pc <= word_align(redirect_pc);
      end else if (w_hs) begin
         r_pc <= r_pc + PC_STEP;
      end
   end

   // Flush flag: marks the outstanding request as stale until its response returns
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_flush <= 1'b0;
      end else begin
         case (r_state)
            FETCH: begin
               r_flush <= imem_gnt && redirect_valid;
            end
            WAIT_RESP: begin
               if (imem_rvalid) begin
                  r_flush <= 1'b0;
               end else if (redirect_valid) begin
                  r_flush <= 1'b1;
               end
            end
            default: begin
               r_flush <= 1'b0;
            end
         endcase
      end
   end

   fetch_out_buf u_out_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_clear  (w_clear),
      .i_squash (w_squash),
      .i_instr  (imem_rdata),
      .i_pc     (r_pc),
      .o_instr  (dec_instr),
      .o_pc     (dec_pc),
      .o_valid  (w_dec_valid)
   );

   assign dec_valid = w_dec_valid;
   assign opcode    = dec_instr[OPC_MSB:OPC_LSB];
   assign funct     = dec_instr[FUNCT_MSB:FUNCT_LSB];

`ifdef FETCH_STALL_COUNT_EN
   logic [31:0] r_stall_cnt;

   // Count decode back-pressure cycles, saturating at all ones
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_cnt <= 32'd0;
      end else if (w_dec_valid && !dec_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// +----------------------------------------------------------------------+
// | Module      : tb_instr_fetch                                         |
// | Description : Self-checking bench for instr_fetch: directed scenario |
// |               tasks plus a randomized run against a transaction-level|
// |               reference model of the fetch PC stream.                |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_ready;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic [5:0]  opcode;
   logic [5:0]  funct;

   logic        wrap_imem_req;
   logic [31:0] wrap_imem_addr;
   logic        wrap_dec_valid;
   logic [31:0] wrap_dec_instr;
   logic [31:0] wrap_dec_pc;
   logic [5:0]  wrap_opcode;
   logic [5:0]  wrap_funct;

`ifdef FETCH_STALL_COUNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] wrap_stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   instr_fetch u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_ready      (dec_ready),
      .dec_valid      (dec_valid),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .opcode         (opcode),
      .funct          (funct)
`ifdef FETCH_STALL_COUNT_EN
      ,
      .stall_cnt      (stall_cnt)
`endif
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (wrap_imem_req),
      .imem_addr      (wrap_imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_ready      (dec_ready),
      .dec_valid      (wrap_dec_valid),
      .dec_instr      (wrap_dec_instr),
      .dec_pc         (wrap_dec_pc),
      .opcode         (wrap_opcode),
      .funct          (wrap_funct)
`ifdef FETCH_STALL_COUNT_EN
      ,
      .stall_cnt      (wrap_stall_cnt)
`endif
   );

   // Instruction memory contents: a fixed scramble of the address
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'd0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      dec_ready      = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Stimulus only: grant now, respond with memory data one cycle later
   task automatic drive_fetch(input logic [31:0] pc);
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pc);
      tick();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_req: got req=%0b addr=%h, want req=1 addr=00000000", imem_req, imem_addr);
      end
      drive_fetch(32'd0);
      rst_n = 1'b0;
      tick();
      n_checks++;
      if (dec_valid !== 1'b0 || dec_pc !== 32'd0 || dec_instr !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_out: got valid=%0b pc=%h instr=%h, want 0/0/0", dec_valid, dec_pc, dec_instr);
      end
      n_checks++;
      if (opcode !== 6'd0 || funct !== 6'd0) begin
         n_errors++;
         $display("FAIL reset_fields: got opcode=%h funct=%h, want 0/0", opcode, funct);
      end
`ifdef FETCH_STALL_COUNT_EN
      n_checks++;
      if (stall_cnt !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_stall: got %0d, want 0", stall_cnt);
      end
`endif
      rst_n = 1'b1;
      n_checks++;
      if (imem_req !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release_req: got %0b, want 1", imem_req);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      logic [31:0] w;
      do_reset();
      dec_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_pc = 32'(i * 4);
         w      = mem_word(exp_pc);
         n_checks++;
         if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            n_errors++;
            $display("FAIL seq_req[%0d]: got req=%0b addr=%h, want req=1 addr=%h", i, imem_req, imem_addr, exp_pc);
         end
         imem_gnt = 1'b1;
         tick();
         imem_gnt = 1'b0;
         n_checks++;
         if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL seq_wait[%0d]: got req=%0b valid=%0b, want 0/0", i, imem_req, dec_valid);
         end
         imem_rvalid = 1'b1;
         imem_rdata  = w;
         tick();
         imem_rvalid = 1'b0;
         n_checks++;
         if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_instr !== w) begin
            n_errors++;
            $display("FAIL seq_present[%0d]: got valid=%0b pc=%h instr=%h, want 1 %h %h", i, dec_valid, dec_pc, dec_instr, exp_pc, w);
         end
         n_checks++;
         if (opcode !== w[31:26] || funct !== w[5:0]) begin
            n_errors++;
            $display("FAIL seq_fields[%0d]: got opcode=%h funct=%h, want %h %h", i, opcode, funct, w[31:26], w[5:0]);
         end
         tick();
      end
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hC || dec_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL seq_next: got req=%0b addr=%h valid=%0b, want 1 0000000c 0", imem_req, imem_addr, dec_valid);
      end
   endtask

   task automatic test_stall();
      do_reset();
      drive_fetch(32'd0);
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (dec_valid !== 1'b1 || dec_instr !== mem_word(32'd0) || imem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_hold[%0d]: got valid=%0b instr=%h req=%0b, want 1 %h 0", i, dec_valid, dec_instr, imem_req, mem_word(32'd0));
         end
         tick();
      end
`ifdef FETCH_STALL_COUNT_EN
      n_checks++;
      if (stall_cnt !== 32'd5) begin
         n_errors++;
         $display("FAIL stall_cnt: got %0d, want 5", stall_cnt);
      end
`endif
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h4 || dec_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL stall_release: got req=%0b addr=%h valid=%0b, want 1 00000004 0", imem_req, imem_addr, dec_valid);
      end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      dec_ready = 1'b1;
      imem_gnt  = 1'b1;
      tick();
      imem_gnt       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      n_checks++;
      if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL rdw_wait: got req=%0b valid=%0b, want 0/0", imem_req, dec_valid);
      end
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(32'd0);
      tick();
      imem_rvalid = 1'b0;
      n_checks++;
      if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
         n_errors++;
         $display("FAIL rdw_discard: got valid=%0b req=%0b addr=%h, want 0 1 00000100", dec_valid, imem_req, imem_addr);
      end
      tick();
      n_checks++;
      if (dec_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL rdw_late: got valid=%0b, want 0", dec_valid);
      end
      // Redirect in the same cycle as the response
      imem_gnt = 1'b1;
      tick();
      imem_gnt       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h2222_2227;
      imem_rvalid    = 1'b1;
      imem_rdata     = mem_word(32'h100);
      tick();
      redirect_valid = 1'b0;
      imem_rvalid    = 1'b0;
      n_checks++;
      if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h2222_2224) begin
         n_errors++;
         $display("FAIL rdw_same: got valid=%0b req=%0b addr=%h, want 0 1 22222224", dec_valid, imem_req, imem_addr);
      end
      dec_ready = 1'b0;
      drive_fetch(32'h2222_2224);
      n_checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h2222_2224 || dec_instr !== mem_word(32'h2222_2224)) begin
         n_errors++;
         $display("FAIL rdw_target: got valid=%0b pc=%h instr=%h, want 1 22222224 %h", dec_valid, dec_pc, dec_instr, mem_word(32'h2222_2224));
      end
   endtask

   task automatic test_redirect_hold();
      do_reset();
      drive_fetch(32'd0);
      dec_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_2000;
      tick();
      redirect_valid = 1'b0;
      dec_ready      = 1'b0;
      n_checks++;
      if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_2000) begin
         n_errors++;
         $display("FAIL rdh_consume: got valid=%0b req=%0b addr=%h, want 0 1 00002000", dec_valid, imem_req, imem_addr);
      end
      drive_fetch(32'h2000);
      n_checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h2000) begin
         n_errors++;
         $display("FAIL rdh_target: got valid=%0b pc=%h, want 1 00002000", dec_valid, dec_pc);
      end
      // Squash: redirect while decode is not ready
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_3001;
      tick();
      redirect_valid = 1'b0;
      n_checks++;
      if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
         n_errors++;
         $display("FAIL rdh_squash: got valid=%0b req=%0b addr=%h, want 0 1 00003000", dec_valid, imem_req, imem_addr);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      n_checks++;
      if (wrap_imem_req !== 1'b1 || wrap_imem_addr !== 32'hFFFF_FFFC) begin
         n_errors++;
         $display("FAIL wrap_start: got req=%0b addr=%h, want 1 fffffffc", wrap_imem_req, wrap_imem_addr);
      end
      drive_fetch(32'hFFFF_FFFC);
      n_checks++;
      if (wrap_dec_valid !== 1'b1 || wrap_dec_pc !== 32'hFFFF_FFFC || wrap_dec_instr !== mem_word(32'hFFFF_FFFC)) begin
         n_errors++;
         $display("FAIL wrap_present: got valid=%0b pc=%h instr=%h, want 1 fffffffc %h", wrap_dec_valid, wrap_dec_pc, wrap_dec_instr, mem_word(32'hFFFF_FFFC));
      end
      n_checks++;
      if ({wrap_opcode, wrap_funct} !== {wrap_dec_instr[31:26], wrap_dec_instr[5:0]}) begin
         n_errors++;
         $display("FAIL wrap_fields: got opcode=%h funct=%h, want fields of %h", wrap_opcode, wrap_funct, wrap_dec_instr);
      end
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      n_checks++;
      if (wrap_imem_req !== 1'b1 || wrap_imem_addr !== 32'h0000_0000) begin
         n_errors++;
         $display("FAIL wrap_next: got req=%0b addr=%h, want 1 00000000", wrap_imem_req, wrap_imem_addr);
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      rst_n       = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(32'd0);
      tick();
      imem_rvalid = 1'b0;
      tick();
      rst_n = 1'b1;
      n_checks++;
      if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
         n_errors++;
         $display("FAIL rstmid_release: got valid=%0b req=%0b addr=%h, want 0 1 00000000", dec_valid, imem_req, imem_addr);
      end
      tick();
      n_checks++;
      if (dec_valid !== 1'b0 || imem_req !== 1'b1) begin
         n_errors++;
         $display("FAIL rstmid_after: got valid=%0b req=%0b, want 0 1", dec_valid, imem_req);
      end
   endtask

   // Randomized traffic against a model of the architectural fetch stream
   task automatic test_random();
      logic [31:0] m_pc;
      logic [31:0] m_req_addr;
      bit          m_out;
      bit          m_flushed;
      bit          m_valid;
      bit          nxt_valid;
      bit          exp_req;
      bit          hs;
      bit          deliver;
      bit          grant;
`ifdef FETCH_STALL_COUNT_EN
      logic [31:0] m_stall;
      m_stall = 32'd0;
`endif
      do_reset();
      m_pc       = 32'd0;
      m_req_addr = 32'd0;
      m_out      = 1'b0;
      m_flushed  = 1'b0;
      m_valid    = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         exp_req = !m_out && !m_valid;
         n_checks++;
         if (dec_valid !== m_valid) begin
            n_errors++;
            $display("FAIL rnd_valid@%0d: got %0b, want %0b", cyc, dec_valid, m_valid);
         end
         n_checks++;
         if (imem_req !== exp_req) begin
            n_errors++;
            $display("FAIL rnd_req@%0d: got %0b, want %0b", cyc, imem_req, exp_req);
         end
         if (exp_req) begin
            n_checks++;
            if (imem_addr !== m_pc) begin
               n_errors++;
               $display("FAIL rnd_addr@%0d: got %h, want %h", cyc, imem_addr, m_pc);
            end
         end
         if (m_valid) begin
            n_checks++;
            if (dec_pc !== m_pc || dec_instr !== mem_word(m_pc)) begin
               n_errors++;
               $display("FAIL rnd_present@%0d: got pc=%h instr=%h, want %h %h", cyc, dec_pc, dec_instr, m_pc, mem_word(m_pc));
            end
         end
`ifdef FETCH_STALL_COUNT_EN
         n_checks++;
         if (stall_cnt !== m_stall) begin
            n_errors++;
            $display("FAIL rnd_stall@%0d: got %0d, want %0d", cyc, stall_cnt, m_stall);
         end
`endif
         imem_gnt       = ($urandom_range(0, 2) != 0);
         dec_ready      = 1'($urandom_range(0, 1));
         redirect_valid = ($urandom_range(0, 9) == 0);
         redirect_pc    = $urandom;
         if (m_out) begin
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = mem_word(m_req_addr);
         end else begin
            imem_rvalid = ($urandom_range(0, 7) == 0);
            imem_rdata  = $urandom;
         end
         hs        = m_valid && dec_ready;
         deliver   = m_out && imem_rvalid;
         grant     = exp_req && imem_gnt;
         nxt_valid = (deliver && !m_flushed && !redirect_valid) ||
                     (m_valid && !dec_ready && !redirect_valid);
`ifdef FETCH_STALL_COUNT_EN
         if (m_valid && !dec_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
         if (grant) begin
            m_out      = 1'b1;
            m_flushed  = redirect_valid;
            m_req_addr = m_pc;
         end else if (deliver) begin
            m_out     = 1'b0;
            m_flushed = 1'b0;
         end else if (m_out && redirect_valid) begin
            m_flushed = 1'b1;
         end
         if (redirect_valid) m_pc = {redirect_pc[31:2], 2'b00};
         else if (hs)        m_pc = m_pc + 32'd4;
         m_valid = nxt_valid;
         tick();
      end
      idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_wrap();
      test_reset_midflight();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
